// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command priority encoding, legal burst check
// and default burst/CAS limits used by both the command sequencer and the OE sequencer.
package sdram_pkg;

  localparam int unsigned DEF_MAX_BURST = 8;
  localparam int unsigned DEF_MAX_CAS   = 3;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE,
    CMD_REF
  } cmd_e;

  // Refresh beats precharge beats write beats read; losers are dropped entirely.
  function automatic cmd_e cmd_decode(input logic refresh, input logic precharge,
                                      input logic wr, input logic rd);
    cmd_e cmd;
    cmd = CMD_NOP;
    if (refresh)        cmd = CMD_REF;
    else if (precharge) cmd = CMD_PRE;
    else if (wr)        cmd = CMD_WRITE;
    else if (rd)        cmd = CMD_READ;
    return cmd;
  endfunction

  function automatic logic burst_legal(input int unsigned len, input int unsigned max_burst);
    return (len != 0) && ((len & (len - 1)) == 0) && (len <= max_burst);
  endfunction

endpackage

// File: rtl/oe_beat_counter.sv
// Beat counter shared by the write and read strobe paths: loads a length (or enters
// open-ended page mode) and reports a registered active flag while beats remain.
module oe_beat_counter #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_page,
  input  logic             i_clear,
  input  logic             i_term,
  output logic             o_active
);

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_page;
  logic             w_page_nxt;
  logic             r_active;
  logic             w_active_nxt;

  // Clear wins over a load; a load wins over a page-only terminate.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_page_nxt = r_page;
    if (i_clear) begin
      w_cnt_nxt  = '0;
      w_page_nxt = 1'b0;
    end else if (i_load) begin
      w_page_nxt = i_page;
      w_cnt_nxt  = i_page ? '0 : i_len;
    end else begin
      if (i_term) w_page_nxt = 1'b0;
      if (r_cnt != '0) w_cnt_nxt = r_cnt - LEN_W'(1);
    end
    w_active_nxt = w_page_nxt || (w_cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_page   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_page   <= w_page_nxt;
      r_active <= w_active_nxt;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/sdram_oe_sequencer.sv
// SDRAM data-path strobe sequencer: write oe/oe4, read data-valid and config error flag.
// Read strobe logic is built only when OE_SEQ_RD_VALID_EN is defined.
module sdram_oe_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned BURST_W   = 4,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned CAS_W     = 2,
  parameter int unsigned MAX_CAS   = DEF_MAX_CAS,
  parameter int unsigned WR_LAT    = 1,
  parameter int unsigned RD_PIPE   = 1
) (
  input  logic               clk0,
  input  logic               reset,
  input  logic               page_mod,
  input  logic               do_writea1,
  input  logic               do_reada,
  input  logic               do_preacharge,
  input  logic               do_refresh,
  input  logic [BURST_W-1:0] bur_len,
  input  logic [CAS_W-1:0]   cas_lat,
  output logic               oe,
  output logic               oe4,
  output logic               rd_valid,
  output logic               cfg_err
);

  localparam int unsigned LEN_W = BURST_W + 1;

  cmd_e             w_cmd;
  logic             w_any_cmd;
  logic             w_len_ok;
  logic             w_cfg_bad;
  logic [LEN_W-1:0] w_len;
  logic             r_cfg_err;
  logic             r_oe;

  assign w_cmd     = cmd_decode(do_refresh, do_preacharge, do_writea1, do_reada);
  assign w_any_cmd = do_refresh || do_preacharge || do_writea1 || do_reada;
  assign w_len_ok  = burst_legal(32'(bur_len), MAX_BURST);
  assign w_len     = w_len_ok ? LEN_W'(bur_len) : LEN_W'(1);

  // ---------------- write path ----------------
  logic             w_wr_start;
  logic             w_wr_clr;
  logic             w_wr_term;
  logic             w_wr_exit;
  logic             w_wr_exit_page;
  logic [LEN_W-1:0] w_wr_exit_len;
  logic             w_oe4;

  assign w_wr_start = (w_cmd == CMD_WRITE);
  assign w_wr_clr   = (w_cmd == CMD_REF) || (w_cmd == CMD_PRE);
  assign w_wr_term  = (w_cmd == CMD_READ);

  // The command cycle itself is the first start stage, so WR_LAT-1 registers remain.
  generate
    if (WR_LAT <= 1) begin : g_wr_direct
      assign w_wr_exit      = w_wr_start;
      assign w_wr_exit_page = page_mod;
      assign w_wr_exit_len  = w_len;
    end else begin : g_wr_pipe
      localparam int unsigned D = WR_LAT - 1;
      logic [D-1:0]     r_vld;
      logic [D-1:0]     r_page;
      logic [LEN_W-1:0] r_len [D];

      always_ff @(posedge clk0) begin
        if (reset || w_wr_clr) begin
          r_vld  <= '0;
          r_page <= '0;
          for (int i = 0; i < int'(D); i++) r_len[i] <= '0;
        end else begin
          r_vld[0]  <= w_wr_start;
          r_page[0] <= page_mod;
          r_len[0]  <= w_len;
          for (int i = 1; i < int'(D); i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_page[i] <= r_page[i-1];
            r_len[i]  <= r_len[i-1];
          end
        end
      end

      assign w_wr_exit      = r_vld[D-1];
      assign w_wr_exit_page = r_page[D-1];
      assign w_wr_exit_len  = r_len[D-1];
    end
  endgenerate

  oe_beat_counter #(.LEN_W(LEN_W)) u_wr_cnt (
    .clk      (clk0),
    .reset    (reset),
    .i_load   (w_wr_exit),
    .i_len    (w_wr_exit_len),
    .i_page   (w_wr_exit_page),
    .i_clear  (w_wr_clr),
    .i_term   (w_wr_term),
    .o_active (w_oe4)
  );

`ifdef OE_SEQ_RD_VALID_EN
  // ---------------- read path ----------------
  localparam int unsigned RD_D  = MAX_CAS + RD_PIPE;
  localparam int unsigned TAP_W = $clog2(RD_D + 1);

  logic             w_cas_ok;
  logic [CAS_W-1:0] w_cas_eff;
  logic [TAP_W-1:0] w_tap;
  logic             w_rd_ld;
  logic             w_rd_tm;
  logic             w_rd_ins;
  logic             w_ins_now;
  logic [RD_D-1:0]  r_rd_ld, w_rd_ld_nxt;
  logic [RD_D-1:0]  r_rd_tm, w_rd_tm_nxt;
  logic [RD_D-1:0]  r_rd_pg, w_rd_pg_nxt;
  logic [LEN_W-1:0] r_rd_len [RD_D];
  logic [LEN_W-1:0] w_rd_len_nxt [RD_D];
  logic             w_fire_ld;
  logic             w_fire_tm;
  logic             w_fire_pg;
  logic [LEN_W-1:0] w_fire_len;
  logic             w_rd_active;

  assign w_cas_ok  = (cas_lat != '0) && (32'(cas_lat) <= MAX_CAS);
  assign w_cfg_bad = !w_len_ok || !w_cas_ok;
  assign w_cas_eff = w_cas_ok ? cas_lat : CAS_W'(MAX_CAS);
  assign w_tap     = TAP_W'(w_cas_eff) + TAP_W'(RD_PIPE) - TAP_W'(1);
  assign w_rd_ld   = (w_cmd == CMD_READ);
  assign w_rd_tm   = (w_cmd inside {CMD_REF, CMD_PRE, CMD_WRITE});
  assign w_rd_ins  = w_rd_ld || w_rd_tm;
  assign w_ins_now = w_rd_ins && (w_tap == '0);

  // Slot j fires j edges from now; a command is dropped straight into its own tap slot.
  always_comb begin
    w_rd_ld_nxt = r_rd_ld >> 1;
    w_rd_tm_nxt = r_rd_tm >> 1;
    w_rd_pg_nxt = r_rd_pg >> 1;
    for (int j = 0; j < int'(RD_D) - 1; j++) w_rd_len_nxt[j] = r_rd_len[j+1];
    w_rd_len_nxt[RD_D-1] = '0;
    for (int j = 0; j < int'(RD_D); j++) begin
      if (w_rd_ins && (w_tap == TAP_W'(j + 1))) begin
        w_rd_ld_nxt[j]  = w_rd_ld;
        w_rd_tm_nxt[j]  = w_rd_tm;
        w_rd_pg_nxt[j]  = page_mod;
        w_rd_len_nxt[j] = w_len;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_rd_ld <= '0;
      r_rd_tm <= '0;
      r_rd_pg <= '0;
      for (int j = 0; j < int'(RD_D); j++) r_rd_len[j] <= '0;
    end else begin
      r_rd_ld <= w_rd_ld_nxt;
      r_rd_tm <= w_rd_tm_nxt;
      r_rd_pg <= w_rd_pg_nxt;
      for (int j = 0; j < int'(RD_D); j++) r_rd_len[j] <= w_rd_len_nxt[j];
    end
  end

  assign w_fire_ld  = w_ins_now ? w_rd_ld  : r_rd_ld[0];
  assign w_fire_tm  = w_ins_now ? w_rd_tm  : r_rd_tm[0];
  assign w_fire_pg  = w_ins_now ? page_mod : r_rd_pg[0];
  assign w_fire_len = w_ins_now ? w_len    : r_rd_len[0];

  oe_beat_counter #(.LEN_W(LEN_W)) u_rd_cnt (
    .clk      (clk0),
    .reset    (reset),
    .i_load   (w_fire_ld),
    .i_len    (w_fire_len),
    .i_page   (w_fire_pg),
    .i_clear  (w_fire_tm),
    .i_term   (1'b0),
    .o_active (w_rd_active)
  );

  assign rd_valid = w_rd_active;
`else
  logic w_unused_rd;

  assign w_cfg_bad   = !w_len_ok;
  assign w_unused_rd = ^{cas_lat, 32'(MAX_CAS), 32'(RD_PIPE)};
  assign rd_valid    = 1'b0;
`endif

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_oe      <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_oe <= w_oe4;
      if (w_any_cmd && w_cfg_bad) r_cfg_err <= 1'b1;
    end
  end

  assign oe4     = w_oe4;
  assign oe      = r_oe;
  assign cfg_err = r_cfg_err;

endmodule
